alu_logic_pipe: RTL and testbench
=================================

Name: alu_logic_pipe

Overview:
Registered, parametrised logic unit that succeeds the 8-bit combinational logic ALU. It adds configurable width, four more operations (NAND, NOR, rotate-left, rotate-right) and valid/ready handshakes on input and output. It also produces registered Zero and Parity flags. It sits between the operand-fetch stage and the result writeback, and can stall either side.

Parameters:
WIDTH, 8, operand/result width in bits; must be a power of two, >= 4.
ROT_ITER, 1, 1 = rotate one bit position per cycle (iterative); 0 = single-cycle barrel rotate.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B; for rotates only B[$clog2(WIDTH)-1:0] is used, as the rotate amount
S  input  3  op select
InValid  input  1  A/B/S valid
InReady  output  1  unit can accept this cycle
Out  output  WIDTH  registered result
OutValid  output  1  Out holds an unconsumed result
OutReady  input  1  consumer accepts Out
Zero  output  1  Out == 0, registered with Out
Parity  output  1  XOR-reduce of Out, registered with Out
Busy  output  1  iterative rotate in progress

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Op codes. The first four are unchanged from the previous ALU:
  - 000 A&B
  - 001 A|B
  - 010 A^B
  - 011 ~A
  - 100 ~(A&B)
  - 101 ~(A|B)
  - 110 rotate A left by amt
  - 111 rotate A right by amt
- Reset (asynchronous, rst_n low): Out=0, OutValid=0, Zero=0, Parity=0, Busy=0, FSM=IDLE, rotate counter=0. Any rotate in flight is aborted and its operands discarded.
- Accept condition: accept = InValid && InReady.
- InReady = (state==IDLE) && (!OutValid || OutReady), combinational.
- Output hold: while OutValid && !OutReady, Out, Zero and Parity must hold stable.
- OutValid clears on OutReady unless a new result is loaded on the same edge.
- FSM states: IDLE and ROT.
- IDLE, logic op accepted (000-101), or rotate with amt==0, or rotate with ROT_ITER==0:
  - Out and flags load on the accepting edge; OutValid=1 after that edge.
  - Latency 1 cycle; throughput 1 result per cycle when OutReady is held high.
- IDLE, rotate with amt != 0 and ROT_ITER==1:
  - On the accepting edge: load work register = A, count = amt, direction = S[0]; go to ROT. Busy=1, InReady=0.
- ROT, on each edge:
  - Rotate the work register by 1 in the stored direction; count decrements.
  - On the edge where count goes 1 to 0: Out = rotated value, flags update, OutValid=1, state returns to IDLE.
  - Total latency = amt cycles from accept.
  - The output register is guaranteed empty on completion, because accept required it empty or draining.
- OutReady during ROT only drains the previous result; it has no effect on the rotate.
- Rotate amount is taken modulo WIDTH by construction, since only log2(WIDTH) bits are used. Rotate by 0 returns A unchanged.
- InValid with InReady=0: ignored. The upstream must hold A, B and S; the unit samples nothing.
- No X outputs: all S codes are defined.

Test Plan:
- WIDTH=8, S=000, A=F0, B=3C, OutReady=1 -> one cycle after accept: Out=30, OutValid=1, Zero=0, Parity=0.
- S=101, A=FF, B=00 -> Out=00, Zero=1, Parity=0. Then S=011, A=FE -> Out=01, Zero=0, Parity=1.
- S=110, A=81, B=03, ROT_ITER=1:
  - Busy=1 and InReady=0 for 3 cycles.
  - OutValid rises exactly 3 cycles after accept with Out=0C.
  - Repeat with S=111, B=0B (amt=3) -> Out=30.
- OutReady=0 after a result: a second request (InValid=1) sees InReady=0. Out stays stable for 5 cycles. Raising OutReady accepts the pending request on the same edge, and the new result follows next cycle.
- OutReady=1: four consecutive logic ops on back-to-back cycles -> four results on four consecutive cycles, none dropped or duplicated.
- Assert rst_n low 2 cycles into an amt=5 rotate -> Out=0, OutValid=0, Busy=0 immediately (asynchronously). After release, InReady=1 and the next AND op completes normally.

Source files
------------

// File: rtl/alu_logic_pipe_if.sv
// Operand/result handshake bundle for alu_logic_pipe.
// The master side feeds operands and consumes results; the slave side is the unit itself.
interface alu_logic_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       S;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] Out;
    logic             OutValid;
    logic             OutReady;
    logic             Zero;
    logic             Parity;
    logic             Busy;

    modport master (
        output A, B, S, InValid, OutReady,
        input  InReady, Out, OutValid, Zero, Parity, Busy
    );

    modport slave (
        input  A, B, S, InValid, OutReady,
        output InReady, Out, OutValid, Zero, Parity, Busy
    );
endinterface

// File: rtl/alu_logic_pipe.sv
// Registered logic unit with valid/ready handshakes, Zero/Parity flags and
// either a one-cycle barrel rotate or an iterative one-bit-per-cycle rotate.
module alu_logic_pipe #(
    parameter int WIDTH    = 8,
    parameter int ROT_ITER = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_logic_pipe_if.slave bus
);
    localparam int AW = $clog2(WIDTH);

    typedef enum logic {IDLE, ROT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [AW-1:0]    count_reg, count_next;
    logic             dir_reg, dir_next;

    logic [WIDTH-1:0] out_reg;
    logic             out_valid_reg;
    logic             zero_reg;
    logic             parity_reg;

    logic             in_ready;
    logic             accept;
    logic [AW-1:0]    amt;
    logic             iter_rot;
    logic [WIDTH-1:0] op_result;
    logic [WIDTH-1:0] step_result;
    logic             load;
    logic [WIDTH-1:0] load_val;

    // Doubling the operand turns a rotate into a plain shift of the concatenation.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input logic [AW-1:0] n);
        logic [2*WIDTH-1:0] t;
        t = {v, v} << n;
        return t[2*WIDTH-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [AW-1:0] n);
        logic [2*WIDTH-1:0] t;
        t = {v, v} >> n;
        return t[WIDTH-1:0];
    endfunction

    assign amt      = bus.B[AW-1:0];
    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || bus.OutReady);
    assign accept   = bus.InValid && in_ready;
    // Only non-zero rotates in iterative mode take the multi-cycle path.
    assign iter_rot = (ROT_ITER != 0) && bus.S[2] && bus.S[1] && (amt != '0);

    always_comb begin
        op_result = '0;
        case (bus.S)
            3'b000:  op_result = bus.A & bus.B;
            3'b001:  op_result = bus.A | bus.B;
            3'b010:  op_result = bus.A ^ bus.B;
            3'b011:  op_result = ~bus.A;
            3'b100:  op_result = ~(bus.A & bus.B);
            3'b101:  op_result = ~(bus.A | bus.B);
            3'b110:  op_result = rotl(bus.A, amt);
            default: op_result = rotr(bus.A, amt);
        endcase
    end

    assign step_result = dir_reg ? {work_reg[0], work_reg[WIDTH-1:1]}
                                 : {work_reg[WIDTH-2:0], work_reg[WIDTH-1]};

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        count_next = count_reg;
        dir_next   = dir_reg;
        load       = 1'b0;
        load_val   = '0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (iter_rot) begin
                        state_next = ROT;
                        work_next  = bus.A;
                        count_next = amt;
                        dir_next   = bus.S[0];
                    end else begin
                        load     = 1'b1;
                        load_val = op_result;
                    end
                end
            end
            ROT: begin
                work_next  = step_result;
                count_next = count_reg - 1'b1;
                if (count_reg == AW'(1)) begin
                    load       = 1'b1;
                    load_val   = step_result;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            count_reg <= '0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            count_reg <= count_next;
            dir_reg   <= dir_next;
        end
    end

    // Output register: a new load wins over a drain on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            zero_reg      <= 1'b0;
            parity_reg    <= 1'b0;
        end else if (load) begin
            out_reg       <= load_val;
            out_valid_reg <= 1'b1;
            zero_reg      <= (load_val == '0);
            parity_reg    <= ^load_val;
        end else if (bus.OutReady) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.Out      = out_reg;
    assign bus.OutValid = out_valid_reg;
    assign bus.Zero     = zero_reg;
    assign bus.Parity   = parity_reg;
    assign bus.Busy     = (state_reg == ROT);
endmodule

// File: tb/tb_alu_logic_pipe.sv
// Directed bench for alu_logic_pipe: expected results are queued on accept and
// compared by a monitor when each result is consumed.
module tb_alu_logic_pipe;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;
    int   npop;
    int   pop_cyc[$];
    logic [WIDTH+1:0] exp_q[$];

    alu_logic_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_logic_pipe #(.WIDTH(WIDTH), .ROT_ITER(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {result, zero, parity}; rotates done one bit at a time.
    function automatic logic [WIDTH+1:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        logic [7:0] r;
        case (s)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a ^ b;
            3'b011: r = ~a;
            3'b100: r = ~(a & b);
            3'b101: r = ~(a | b);
            default: begin
                r = a;
                for (int i = 0; i < int'(b[2:0]); i++)
                    r = s[0] ? {r[0], r[7:1]} : {r[6:0], r[7]};
            end
        endcase
        return {r, (r == 8'h00), ^r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: every consumed result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.OutValid && bus.OutReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {22'd0, bus.Out, bus.Zero, bus.Parity}, 32'hFFFF_FFFF);
            end else begin
                logic [WIDTH+1:0] e;
                e = exp_q.pop_front();
                chk($sformatf("result_c%0d", cyc), {22'd0, bus.Out, bus.Zero, bus.Parity}, {22'd0, e});
                $display("[TB] cycle %0d result Out=%02h Zero=%0b Parity=%0b", cyc, bus.Out, bus.Zero, bus.Parity);
            end
            npop++;
            pop_cyc.push_back(cyc);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        bit done;
        done = 1'b0;
        bus.A = a; bus.B = b; bus.S = s; bus.InValid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.InReady) begin
                exp_q.push_back(model(a, b, s));
                $display("[TB] cycle %0d accept S=%03b A=%02h B=%02h", cyc, s, a, b);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        bus.InValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; npop = 0;
        rst_n = 1'b0;
        bus.A = '0; bus.B = '0; bus.S = '0; bus.InValid = 1'b0; bus.OutReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out",      bus.Out,      32'h0);
        chk("rst_outvalid", bus.OutValid, 32'h0);
        chk("rst_zero",     bus.Zero,     32'h0);
        chk("rst_parity",   bus.Parity,   32'h0);
        chk("rst_busy",     bus.Busy,     32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic AND with one-cycle latency.
        send(8'hF0, 8'h3C, 3'b000);
        @(negedge clk);
        chk("and_latency_valid", bus.OutValid, 32'h1);
        chk("and_latency_out",   bus.Out,      32'h30);
        @(posedge clk); #1;

        send(8'hFF, 8'h00, 3'b101);
        send(8'hFE, 8'h00, 3'b011);
        send(8'h5A, 8'hC3, 3'b010);
        send(8'h0F, 8'h0C, 3'b100);
        drain();

        // Iterative rotate left by 3: busy for exactly three cycles.
        send(8'h81, 8'h03, 3'b110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rotl_busy",    bus.Busy,     32'h1);
            chk("rotl_inready", bus.InReady,  32'h0);
            chk("rotl_novalid", bus.OutValid, 32'h0);
        end
        @(negedge clk);
        chk("rotl_valid", bus.OutValid, 32'h1);
        chk("rotl_out",   bus.Out,      32'h0C);
        @(posedge clk); #1;

        send(8'h81, 8'h0B, 3'b111);
        drain();
        send(8'h81, 8'h08, 3'b110);
        drain();

        // Output stall: result held, next request blocked until OutReady rises.
        bus.OutReady = 1'b0;
        send(8'h0F, 8'hFF, 3'b000);
        bus.A = 8'hAA; bus.B = 8'h55; bus.S = 3'b001; bus.InValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_inready", bus.InReady,  32'h0);
            chk("stall_valid",   bus.OutValid, 32'h1);
            chk("stall_out",     bus.Out,      32'h0F);
            @(posedge clk); #1;
        end
        bus.OutReady = 1'b1;
        @(negedge clk);
        chk("stall_release_inready", bus.InReady, 32'h1);
        exp_q.push_back(model(8'hAA, 8'h55, 3'b001));
        @(posedge clk); #1;
        bus.InValid = 1'b0;
        @(negedge clk);
        chk("stall_next_valid", bus.OutValid, 32'h1);
        chk("stall_next_out",   bus.Out,      32'hFF);
        @(posedge clk); #1;
        drain();

        // Back-to-back throughput.
        begin
            int base;
            base = npop;
            send(8'h12, 8'h34, 3'b000);
            send(8'h12, 8'h34, 3'b001);
            send(8'h12, 8'h34, 3'b010);
            send(8'h12, 8'h34, 3'b101);
            drain();
            chk("b2b_count", npop - base, 32'd4);
            chk("b2b_consecutive", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-4], 32'd3);
        end

        // Reset aborts an in-flight rotate.
        send(8'h81, 8'h05, 3'b110);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out",      bus.Out,      32'h0);
        chk("abort_outvalid", bus.OutValid, 32'h0);
        chk("abort_busy",     bus.Busy,     32'h0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_inready", bus.InReady, 32'h1);
        @(posedge clk); #1;
        send(8'hC3, 8'h81, 3'b000);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
